// File: rtl/io_port_pkg.sv
// io_port_pkg: shared register offsets and read-mux helpers for the I/O port bank
package io_port_pkg;
    localparam int OFS_W = 2;
    localparam logic [OFS_W-1:0] REG_DDR  = 2'd0;
    localparam logic [OFS_W-1:0] REG_DATA = 2'd1;
    localparam logic [OFS_W-1:0] REG_SET  = 2'd2;
    localparam logic [OFS_W-1:0] REG_CLR  = 2'd3;

    // Fill bit replicated across the read bus for addresses beyond the bank
    function automatic logic unmapped_fill();
        return 1'b1;
    endfunction
endpackage

// File: rtl/io_port_bank_if.sv
// io_port_bank_if: CPU system-bus side of the I/O port bank
interface io_port_bank_if #(
    parameter int AW     = 3,
    parameter int DATA_W = 8
);
    logic              ready;
    logic              cs;
    logic [AW-1:0]     addr;
    logic              bus_write;
    logic [DATA_W-1:0] data_i;
    logic [DATA_W-1:0] data_o;

    modport master (output ready, cs, addr, bus_write, data_i, input data_o);
    modport slave  (input ready, cs, addr, bus_write, data_i, output data_o);
endinterface

// File: rtl/io_port_fade_bit.sv
// io_port_fade_bit: holds the last written value on an undriven pin for FADE_CYCLES clocks, then reads 0
module io_port_fade_bit
    import io_port_pkg::*;
#(
    parameter int FADE_CYCLES = 1024
) (
    input  logic clk,
    input  logic reset,
    input  logic ddr,
    input  logic value,
    output logic in_eff
);
    localparam int CW = $clog2(FADE_CYCLES + 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk)
        if (reset) cnt <= CW'(FADE_CYCLES);
        else       cnt <= ddr ? CW'(FADE_CYCLES) : cnt - CW'(cnt != '0);

    assign in_eff = value & (cnt != '0);
endmodule

// File: rtl/io_port_bank.sv
// io_port_bank: NUM_PORTS DDR/DATA I/O ports with SET/CLR aliases and synchronised pins.
// Define IO_PORT_FADE_EN to let FADE_MASK bits hold their written value for FADE_CYCLES once undriven.
module io_port_bank
    import io_port_pkg::*;
#(
    parameter int                NUM_PORTS   = 2,
    parameter int                DATA_W      = 8,
    parameter logic [DATA_W-1:0] RESET_DDR   = 'hFF,
    parameter logic [DATA_W-1:0] RESET_VALUE = 'h3F,
    parameter logic [DATA_W-1:0] FADE_MASK   = 'hC0,
    parameter int                FADE_CYCLES = 1024
) (
    input  logic                        clk,
    input  logic                        reset,
    io_port_bank_if.slave               bus,
    input  logic [NUM_PORTS*DATA_W-1:0] pins_i,
    output logic [NUM_PORTS*DATA_W-1:0] ddr_o,
    output logic [NUM_PORTS*DATA_W-1:0] value_o,
    output logic [NUM_PORTS*DATA_W-1:0] drive_o
);
    localparam int W = NUM_PORTS * DATA_W;
`ifdef IO_PORT_FADE_EN
    localparam bit FADE_ON = 1'b1;
`else
    localparam bit FADE_ON = 1'b0;
`endif

    logic [W-1:0]         sync1, in_sync, in_eff;
    logic [NUM_PORTS-1:0] hit;
    logic [DATA_W-1:0]    rd_port [NUM_PORTS];
    logic [DATA_W-1:0]    rd_mux;
    logic                 access, wr, mapped;
    logic [OFS_W-1:0]     ofs;

    assign access = bus.cs & bus.ready;
    assign wr     = access & bus.bus_write;
    assign ofs    = bus.addr[OFS_W-1:0];
    assign mapped = int'(bus.addr) < 4 * NUM_PORTS;

    always_ff @(posedge clk)
        if (reset) begin
            sync1   <= '0;
            in_sync <= '0;
        end else begin
            sync1   <= pins_i;
            in_sync <= sync1;
        end

    for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
        logic [DATA_W-1:0] ddr, value, pin_rd;
        assign hit[p]     = mapped && int'(bus.addr >> OFS_W) == p;
        assign pin_rd     = (value & ddr) | (in_eff[p*DATA_W +: DATA_W] & ~ddr);
        assign rd_port[p] = ofs == REG_DDR ? ddr : pin_rd;
        assign ddr_o[p*DATA_W +: DATA_W]   = ddr;
        assign value_o[p*DATA_W +: DATA_W] = value;
        always_ff @(posedge clk)
            if (reset) begin
                ddr   <= RESET_DDR;
                value <= RESET_VALUE;
            end else if (wr && hit[p]) begin
                ddr   <= ofs == REG_DDR ? bus.data_i : ddr;
                value <= ofs == REG_DATA ? bus.data_i :
                         ofs == REG_SET  ? value | bus.data_i :
                         ofs == REG_CLR  ? value & ~bus.data_i : value;
            end
        for (genvar b = 0; b < DATA_W; b++) begin : g_bit
            if (FADE_ON && FADE_MASK[b]) begin : g_fade
                io_port_fade_bit #(.FADE_CYCLES(FADE_CYCLES)) u_fade (
                    .clk    (clk),
                    .reset  (reset),
                    .ddr    (ddr[b]),
                    .value  (value[b]),
                    .in_eff (in_eff[p*DATA_W+b])
                );
            end else begin : g_sync
                assign in_eff[p*DATA_W+b] = in_sync[p*DATA_W+b];
            end
        end
    end

    assign drive_o = value_o & ddr_o;

    always_comb begin
        rd_mux = {DATA_W{unmapped_fill()}};
        for (int p = 0; p < NUM_PORTS; p++)
            rd_mux = hit[p] ? rd_port[p] : rd_mux;
    end

    always_ff @(posedge clk)
        if (reset)                          bus.data_o <= '0;
        else if (access && !bus.bus_write)  bus.data_o <= rd_mux;
endmodule

// File: tb/tb_io_port_bank.sv
// tb_io_port_bank: directed checks of the I/O port bank (2-port main instance, 3-port instance for unmapped space)
module tb_io_port_bank;
`ifdef IO_PORT_FADE_EN
    localparam bit FADE = 1'b1;
`else
    localparam bit FADE = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] pins = '0;
    logic [15:0] ddr_o, value_o, drive_o;
    logic [23:0] pins3 = '0;
    logic [23:0] ddr3, value3, drive3;
    int          passed = 0;
    int          total = 0;

    io_port_bank_if #(.AW(3), .DATA_W(8)) bus ();
    io_port_bank_if #(.AW(4), .DATA_W(8)) bus3 ();

    io_port_bank #(.NUM_PORTS(2), .FADE_CYCLES(16)) dut (
        .clk     (clk),
        .reset   (reset),
        .bus     (bus.slave),
        .pins_i  (pins),
        .ddr_o   (ddr_o),
        .value_o (value_o),
        .drive_o (drive_o)
    );

    io_port_bank #(.NUM_PORTS(3), .FADE_CYCLES(16)) dut3 (
        .clk     (clk),
        .reset   (reset),
        .bus     (bus3.slave),
        .pins_i  (pins3),
        .ddr_o   (ddr3),
        .value_o (value3),
        .drive_o (drive3)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got === exp) passed++;
        else $display("FAIL %s got=%h exp=%h", tag, got, exp);
    endtask

    task automatic wr(input logic [2:0] a, input logic [7:0] d);
        @(negedge clk);
        bus.cs = 1'b1; bus.ready = 1'b1; bus.bus_write = 1'b1; bus.addr = a; bus.data_i = d;
        @(negedge clk);
        bus.cs = 1'b0; bus.bus_write = 1'b0;
    endtask

    task automatic rd(input string tag, input logic [2:0] a, input logic [7:0] exp);
        @(negedge clk);
        bus.cs = 1'b1; bus.ready = 1'b1; bus.bus_write = 1'b0; bus.addr = a;
        @(negedge clk);
        bus.cs = 1'b0;
        check(tag, bus.data_o, exp);
    endtask

    initial begin
        bus.cs = 0; bus.ready = 1; bus.bus_write = 0; bus.addr = '0; bus.data_i = '0;
        bus3.cs = 0; bus3.ready = 1; bus3.bus_write = 0; bus3.addr = '0; bus3.data_i = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        check("rst_data_o", bus.data_o, 8'h00);
        check("rst_ddr", ddr_o, 16'hFFFF);
        check("rst_value", value_o, 16'h3F3F);
        check("rst_drive", drive_o, 16'h3F3F);
        rd("rst_rd0", 3'd0, 8'hFF);
        rd("rst_rd1", 3'd1, 8'h3F);
        rd("rst_rd5", 3'd5, 8'h3F);

        // Three-port bank: addresses 12..15 are past the last port
        @(negedge clk);
        bus3.cs = 1; bus3.bus_write = 1; bus3.addr = 4'd12; bus3.data_i = 8'h00;
        @(negedge clk);
        bus3.bus_write = 0;
        @(negedge clk);
        check("unmap_rd12", bus3.data_o, 8'hFF);
        check("unmap_wr_ddr", ddr3, 24'hFFFFFF);
        check("unmap_wr_val", value3, 24'h3F3F3F);
        bus3.addr = 4'd15;
        @(negedge clk);
        check("unmap_rd15", bus3.data_o, 8'hFF);
        bus3.addr = 4'd9;
        @(negedge clk);
        check("p2_rd9", bus3.data_o, 8'h3F);
        bus3.cs = 0;

        // Port 1: mixed DDR, pins visible on input bits
        pins = 16'h3000;
        wr(3'd4, 8'h0F);
        wr(3'd5, 8'hA5);
        repeat (3) @(negedge clk);
        check("p1_drive", drive_o[15:8], 8'h05);
        rd("p1_mix", 3'd5, FADE ? 8'hB5 : 8'h35);

        // SET / CLR aliases on port 0
        wr(3'd1, 8'h10);
        wr(3'd2, 8'h03);
        rd("set_rd1", 3'd1, 8'h13);
        rd("set_rd2", 3'd2, 8'h13);
        wr(3'd3, 8'h11);
        rd("clr_rd3", 3'd3, 8'h02);
        rd("clr_rd1", 3'd1, 8'h02);

        // ready low: neither write nor read completes
        @(negedge clk);
        bus.cs = 1; bus.ready = 0; bus.bus_write = 1; bus.addr = 3'd1; bus.data_i = 8'hFF;
        @(negedge clk);
        bus.bus_write = 0; bus.addr = 3'd0;
        @(negedge clk);
        check("nrdy_value", value_o[7:0], 8'h02);
        check("nrdy_hold", bus.data_o, 8'h02);
        bus.cs = 0; bus.ready = 1;

        // Back-to-back read, write, read
        @(negedge clk);
        bus.cs = 1; bus.bus_write = 0; bus.addr = 3'd1;
        @(negedge clk);
        check("b2b_rd_pre", bus.data_o, 8'h02);
        bus.bus_write = 1; bus.data_i = 8'h55;
        @(negedge clk);
        check("b2b_hold", bus.data_o, 8'h02);
        check("b2b_value", value_o[7:0], 8'h55);
        bus.bus_write = 0;
        @(negedge clk);
        check("b2b_rd_post", bus.data_o, 8'h55);
        bus.bus_write = 1; bus.addr = 3'd0; bus.data_i = 8'h0F;
        @(negedge clk);
        bus.bus_write = 0;
        @(negedge clk);
        check("b2b_ddr", bus.data_o, 8'h0F);
        bus.cs = 0;
        rd("p0_mix", 3'd1, FADE ? 8'h45 : 8'h05);

        // Undriven bits 7:6 with pins low
        wr(3'd1, 8'hC0);
        wr(3'd0, 8'hFF);
        wr(3'd0, 8'h3F);
        bus.cs = 1; bus.bus_write = 0; bus.addr = 3'd1;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            check($sformatf("fade_k%0d", k), bus.data_o, (FADE && k <= 16) ? 8'hC0 : 8'h00);
        end
        pins[7:0] = 8'hC0;
        repeat (2) @(negedge clk);
        check("sync_lat2", bus.data_o, 8'h00);
        @(negedge clk);
        check("sync_lat3", bus.data_o, FADE ? 8'h00 : 8'hC0);

        // Reset wins over a simultaneous write
        bus.bus_write = 1; bus.addr = 3'd0; bus.data_i = 8'h00;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        bus.cs = 0; bus.bus_write = 0;
        check("mid_rst_ddr", ddr_o, 16'hFFFF);
        check("mid_rst_val", value_o, 16'h3F3F);
        check("mid_rst_do", bus.data_o, 8'h00);
        rd("mid_rst_rd0", 3'd0, 8'hFF);
        rd("mid_rst_rd1", 3'd1, 8'h3F);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
